// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage with AXI-style AR/R read port, prefetch FIFO and redirect flush.
// Optional IFETCH_ERR_HALT_EN: stop issuing reads after an error beat until redirect/reset.  Rev 1.0
`default_nettype none

module ifetch_unit #(
  parameter int                 DEPTH    = 4,
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  logic [31:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic              fifo_err  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, outstanding, drop_cnt, out_next;
  logic [ADDR_W-1:0] req_pc, resp_pc, ar_addr_q;
  logic              ar_pend, ar_stale, halted;
  logic              credit_ok, ar_hs, r_hs, push, pop;
  logic [CNT_W:0]    used;

  assign used      = {1'b0, count} + {1'b0, outstanding};
  assign credit_ok = used < (CNT_W + 1)'(DEPTH);

  // A request already presented must stay up, even if credits/halt would now forbid it.
  assign arvalid = ~reset & (ar_pend | (credit_ok & ~halted));
  assign araddr  = ar_stale ? ar_addr_q : req_pc;
  assign rready  = ~reset;

  assign ar_hs    = arvalid & arready;
  assign r_hs     = rvalid & rready;
  assign push     = r_hs & ~redirect & (drop_cnt == '0);
  assign pop      = inst_valid & inst_ready;
  assign out_next = outstanding + CNT_W'(ar_hs) - CNT_W'(r_hs);

  assign inst_valid = ~reset & (count != '0);
  assign inst       = reset ? '0 : fifo_data[rd_ptr];
  assign inst_pc    = reset ? '0 : fifo_pc[rd_ptr];
  assign inst_err   = reset ? 1'b0 : fifo_err[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rdata;
      fifo_pc[wr_ptr]   <= resp_pc;
      fifo_err[wr_ptr]  <= (rresp != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      req_pc      <= RESET_PC & ALIGN_MASK;
      resp_pc     <= RESET_PC & ALIGN_MASK;
      ar_pend     <= 1'b0;
      ar_stale    <= 1'b0;
      ar_addr_q   <= '0;
    end else begin
      ar_pend     <= arvalid & ~arready;
      ar_addr_q   <= araddr;
      outstanding <= out_next;
      if (redirect) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        // Everything in flight, plus a request still waiting for arready, belongs to the old stream.
        drop_cnt <= out_next + CNT_W'(arvalid & ~arready);
        req_pc   <= redirect_pc & ALIGN_MASK;
        resp_pc  <= redirect_pc & ALIGN_MASK;
        ar_stale <= arvalid & ~arready;
      end else begin
        if (ar_hs) begin
          ar_stale <= 1'b0;
          if (!ar_stale) req_pc <= req_pc + PC_STEP;
        end
        if (r_hs && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          resp_pc <= resp_pc + PC_STEP;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

`ifdef IFETCH_ERR_HALT_EN
  always_ff @(posedge clk) begin
    if (reset || redirect) halted <= 1'b0;
    else if (push && rresp != 2'b00) halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with an in-order memory model and an instruction scoreboard.
`default_nettype none

module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] inst, inst_pc;
  logic        inst_err, inst_valid, inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int compared = 0;
  int mismatched = 0;

  logic        mem_hold = 1'b0, err_en = 1'b0, consume_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] mq[$];
  logic [32:0] sb[$];
  int          ar_count = 0;
  logic        m_ar_hs, m_r_hs, m_rst;
  logic [31:0] m_addr;

  ifetch_unit #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hbeef, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory: accepts every AR, returns beats in order one cycle later unless held.
  always begin
    @(negedge clk);
    m_ar_hs = arvalid && arready;
    m_r_hs  = rvalid && rready;
    m_addr  = araddr;
    m_rst   = reset;
    @(posedge clk);
    #1;
    if (m_rst) begin
      mq.delete();
      ar_count = 0;
    end else begin
      if (m_r_hs) void'(mq.pop_front());
      if (m_ar_hs) begin
        mq.push_back(m_addr);
        ar_count++;
      end
    end
    if (!reset && !mem_hold && mq.size() > 0) begin
      rvalid = 1'b1;
      rdata  = mem_word(mq[0]);
      rresp  = (err_en && mq[0] == err_addr) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = 2'b00;
    end
  end

  // Consumer: takes instructions only while the scoreboard expects some.
  always begin
    @(negedge clk);
    if (!reset && inst_valid && inst_ready && sb.size() > 0) begin
      logic [32:0] e;
      e = sb.pop_front();
      check("inst_pc", 64'(inst_pc), 64'(e[31:0]));
      check("inst", 64'(inst), 64'(mem_word(e[31:0])));
      check("inst_err", 64'(inst_err), 64'(e[32]));
    end
    @(posedge clk);
    #1;
    inst_ready = consume_en && (sb.size() > 0);
  end

  task automatic expect_pc(input logic [31:0] pc, input logic err);
    sb.push_back({err, pc});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    consume_en = 1'b0;
    arready = 1'b1;
    mem_hold = 1'b0;
    err_en = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    sb.delete();
    repeat (3) tick();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
    consume_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    inst_ready = 1'b0;
    // Reset values and streaming at one instruction per cycle.
    do_reset();
    @(negedge clk);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
    check("rst_inst_err", 64'(inst_err), 64'd0);
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4), 1'b0);
    consume_en = 1'b1;
    tick();
    reset = 1'b0;
    begin
      int n = 0;
      while (n < 20) begin
        @(negedge clk);
        n++;
        if (inst_valid) break;
      end
      check("first_valid_latency", 64'(n), 64'd3);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("stream_valid", 64'(inst_valid), 64'd1);
    end
    wait_drain("stream_drain");

    // Decoder stalled: credits cap the reads at DEPTH, then drain in order.
    do_reset();
    reset = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("full_ar_count", 64'(ar_count), 64'd4);
    check("full_arvalid", 64'(arvalid), 64'd0);
    check("full_inst_valid", 64'(inst_valid), 64'd1);
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4), 1'b0);
    consume_en = 1'b1;
    wait_drain("full_drain");

    // Four reads in flight at redirect: all four old beats dropped.
    do_reset();
    mem_hold = 1'b1;
    reset = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("inflight_ar_count", 64'(ar_count), 64'd4);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    mem_hold = 1'b0;
    for (int i = 0; i < 4; i++) expect_pc(32'h100 + 32'(i * 4), 1'b0);
    consume_en = 1'b1;
    wait_drain("redir_drain");

    // Redirect while an AR waits for arready: old address held, its beat dropped.
    do_reset();
    arready = 1'b0;
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("pend_arvalid", 64'(arvalid), 64'd1);
    check("pend_araddr", 64'(araddr), 64'd0);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("hold_arvalid", 64'(arvalid), 64'd1);
    check("hold_araddr", 64'(araddr), 64'd0);
    tick();
    arready = 1'b1;
    @(negedge clk);
    check("hold_araddr2", 64'(araddr), 64'd0);
    tick();
    @(negedge clk);
    check("new_araddr", 64'(araddr), 64'h40);
    for (int i = 0; i < 3; i++) expect_pc(32'h40 + 32'(i * 4), 1'b0);
    consume_en = 1'b1;
    wait_drain("pend_drain");

    // Error response on pc 8.
    do_reset();
    err_en = 1'b1;
    err_addr = 32'h8;
`ifdef IFETCH_ERR_HALT_EN
    for (int i = 0; i < 3; i++) expect_pc(32'(i * 4), i == 2);
`else
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4), i == 2);
`endif
    consume_en = 1'b1;
    tick();
    reset = 1'b0;
    wait_drain("err_drain");
    repeat (10) tick();
    @(negedge clk);
`ifdef IFETCH_ERR_HALT_EN
    check("err_halted", 64'(arvalid), 64'd0);
`else
    check("err_continues", 64'(ar_count >= 8), 64'd1);
`endif
    err_en = 1'b0;

    // Redirect coinciding with an R beat and an output pop.
    do_reset();
    mem_hold = 1'b1;
    reset = 1'b0;
    repeat (8) tick();
    mem_hold = 1'b0;
    tick();
    mem_hold = 1'b1;
    tick();
    expect_pc(32'h0, 1'b0);
    consume_en = 1'b1;
    mem_hold = 1'b0;
    @(negedge clk);
    check("combo_valid", 64'(inst_valid), 64'd1);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    consume_en = 1'b0;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("combo_empty", 64'(inst_valid), 64'd0);
    check("combo_popped", 64'(sb.size()), 64'd0);
    expect_pc(32'h200, 1'b0);
    expect_pc(32'h204, 1'b0);
    consume_en = 1'b1;
    wait_drain("combo_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

`default_nettype wire
